// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall / bubble / flush sequencer for the 5-stage integer pipeline.
//   It sits beside decode and produces the load enables for PC/IF, IF/ID,
//   ID/EX and EX/MEM. It also produces the ID/EX bubble request and the IF/ID
//   flush request. Hazards handled, highest priority first: memory wait,
//   multi-cycle EX op, load-use interlock, delay-slot annul.
//
//   Optional feature: define ICC_INTERLOCK_EN to add a one-cycle icc
//   interlock (EX writes icc while ID reads it). When it is left undefined,
//   icc is assumed to be forwarded externally and id_uses_icc is ignored.
//
// Parameters
//   MC_LEN_W     width of the multi-cycle latency field
//   STALL_CNT_W  width of the saturating stall-cycle counter
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   id_*              ID-stage instruction: valid, source regs, which are read
//   ex_*              EX-stage instruction: valid, dest, load/regwrite/icc,
//                     multi-cycle start and total length
//   mem_ready         memory stage can complete this cycle
//   branch_annul      resolved branch annuls its delay slot
//   if_en, ifid_en    fetch advance / IF/ID load enables
//   idex_en           ID/EX load enable (ex_ready)
//   idex_bubble       force a NOP into ID/EX
//   ifid_flush        replace the IF/ID content with a NOP
//   exmem_en          EX/MEM load enable
//   busy              sequencer is not in RUN
//   stall_cnt         saturating count of cycles where ID/EX did not take a
//                     real instruction
module pipe_stall_ctrl #(
    parameter int MC_LEN_W    = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   id_uses_icc,
    input  logic                   ex_valid,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_is_load,
    input  logic                   ex_regwrite,
    input  logic                   ex_icc_write,
    input  logic                   ex_mc_start,
    input  logic [MC_LEN_W-1:0]    ex_mc_len,
    input  logic                   mem_ready,
    input  logic                   branch_annul,
    output logic                   if_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   idex_bubble,
    output logic                   ifid_flush,
    output logic                   exmem_en,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MCYC = 2'd1,
        MEMW = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [MC_LEN_W-1:0]     mc_cnt_q, mc_cnt_d;
    logic                    annul_pend_q, annul_pend_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic fe_en_c;      // shared by PC/IF and IF/ID
    logic idex_en_c;
    logic exmem_en_c;
    logic bubble_c;
    logic flush_c;
    logic lu_hit;
    logic icc_hit;

    // A load whose result ID needs. %g0 is hardwired to zero and never interlocks.
    assign lu_hit = ex_valid & ex_is_load & ex_regwrite & (ex_rd != 5'd0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

`ifdef ICC_INTERLOCK_EN
    assign icc_hit = ex_valid & ex_icc_write & id_valid & id_uses_icc;
`else
    logic unused_icc;
    assign icc_hit    = 1'b0;
    assign unused_icc = id_uses_icc ^ ex_icc_write;
`endif

    always_comb begin
        state_d    = state_q;
        mc_cnt_d   = mc_cnt_q;
        fe_en_c    = 1'b0;
        idex_en_c  = 1'b0;
        exmem_en_c = 1'b0;
        bubble_c   = 1'b0;

        case (state_q)
            RUN: begin
                if (!mem_ready) begin
                    state_d = MEMW;
                end else if (ex_mc_start && (ex_mc_len >= MC_LEN_W'(2))) begin
                    // The entry cycle is the first of ex_mc_len EX cycles.
                    // Counting down to 1 makes the last MCYC cycle the release.
                    mc_cnt_d = ex_mc_len - MC_LEN_W'(1);
                    state_d  = MCYC;
                end else if (lu_hit || icc_hit) begin
                    // Hold IF/ID and let EX drain. A NOP enters ID/EX.
                    idex_en_c  = 1'b1;
                    exmem_en_c = 1'b1;
                    bubble_c   = 1'b1;
                end else begin
                    fe_en_c    = 1'b1;
                    idex_en_c  = 1'b1;
                    exmem_en_c = 1'b1;
                end
            end
            MCYC: begin
                // A memory freeze holds the count where it is.
                if (mem_ready) begin
                    if (mc_cnt_q > MC_LEN_W'(1)) begin
                        mc_cnt_d = mc_cnt_q - MC_LEN_W'(1);
                    end else begin
                        fe_en_c    = 1'b1;
                        idex_en_c  = 1'b1;
                        exmem_en_c = 1'b1;
                        mc_cnt_d   = '0;
                        state_d    = RUN;
                    end
                end
            end
            MEMW: begin
                if (mem_ready) begin
                    fe_en_c    = 1'b1;
                    idex_en_c  = 1'b1;
                    exmem_en_c = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // The annul is applied on the first cycle in which IF/ID actually
        // loads. Until that cycle it stays pending, so a stall neither loses
        // it nor applies it twice.
        flush_c      = fe_en_c & (annul_pend_q | branch_annul);
        annul_pend_d = (annul_pend_q | branch_annul) & ~flush_c;

        stall_cnt_d = stall_cnt_q;
        if ((!idex_en_c || bubble_c) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            mc_cnt_q     <= '0;
            annul_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            mc_cnt_q     <= mc_cnt_d;
            annul_pend_q <= annul_pend_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // All outputs read as zero throughout a reset cycle.
    assign if_en       = fe_en_c & ~reset;
    assign ifid_en     = fe_en_c & ~reset;
    assign idex_en     = idex_en_c & ~reset;
    assign idex_bubble = bubble_c & ~reset;
    assign ifid_flush  = flush_c & ~reset;
    assign exmem_en    = exmem_en_c & ~reset;
    assign busy        = (state_q != RUN) & ~reset;
    assign stall_cnt   = reset ? '0 : stall_cnt_q;

endmodule
